// File: rtl/tile_stream_if.sv
// Tile feeder bus: BRAM read port toward the operand memories and the tile stream toward
// the MAC array. The master (controller) drives reads and tiles; the slave side answers.
interface tile_stream_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TILE_SIZE  = 16,
    parameter int unsigned ADDR_WIDTH = 4
);
    localparam int unsigned TW = TILE_SIZE * TILE_SIZE * DATA_WIDTH;

    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [TW-1:0]         a_rd_data;
    logic [TW-1:0]         b_rd_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [TW-1:0]         a_out;
    logic [TW-1:0]         b_out;
    logic                  acc_en_out;
    logic                  last_out;
    logic [2:0]            mode_out;

    modport master (
        output rd_en, rd_addr,
        input  a_rd_data, b_rd_data,
        output out_valid, a_out, b_out, acc_en_out, last_out, mode_out,
        input  out_ready
    );

    modport slave (
        input  rd_en, rd_addr,
        output a_rd_data, b_rd_data,
        input  out_valid, a_out, b_out, acc_en_out, last_out, mode_out,
        output out_ready
    );
endinterface

// File: rtl/tile_stream_ctrl.sv
// Tile feeder: start/done-controlled burst of BRAM reads with a sideband pipe aligned to
// the read latency, feeding a credit-limited first-word-fall-through FIFO toward the array.
module tile_stream_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TILE_SIZE  = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH = RD_LATENCY + 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   num_tiles_i,
    input  logic [ADDR_WIDTH:0]   k_len_i,
    input  logic [2:0]            mode_i,
    output logic                  busy_o,
    output logic                  done_o,
    tile_stream_if.master         bus
);
    localparam int unsigned TW = TILE_SIZE * TILE_SIZE * DATA_WIDTH;
    localparam int unsigned NW = ADDR_WIDTH + 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                state_q, state_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NW-1:0]         issued_q, issued_d, num_q, num_d;
    logic [NW-1:0]         k_q, k_d, grp_q, grp_d;
    logic [2:0]            mode_q, mode_d;
    logic [CW-1:0]         cred_q, cred_d, fcnt_q, fcnt_d;
    logic [RD_LATENCY-1:0] vld_q, vld_d, acc_q, acc_d, last_q, last_d;
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [TW-1:0]         fa_q [FIFO_DEPTH];
    logic [TW-1:0]         fb_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] facc_q, flast_q;
    logic                  rd_en, push, pop, is_last_rd;

    always_comb begin
        pop        = (fcnt_q != '0) && bus.out_ready;
        push       = vld_q[RD_LATENCY-1];
        is_last_rd = (issued_q == num_q - NW'(1));
        // Credit counts FIFO entries plus reads still travelling through the BRAM pipe.
        rd_en      = (state_q == StRun) && (issued_q != num_q) &&
                     ((cred_q - CW'(pop)) < CW'(FIFO_DEPTH));

        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        addr_d   = addr_q;
        issued_d = issued_q;
        num_d    = num_q;
        k_d      = k_q;
        grp_d    = grp_q;
        mode_d   = mode_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (num_tiles_i != '0) begin
                        state_d  = StRun;
                        busy_d   = 1'b1;
                        addr_d   = base_addr_i;
                        issued_d = '0;
                        num_d    = num_tiles_i;
                        k_d      = (k_len_i == '0) ? NW'(1) : k_len_i;
                        grp_d    = '0;
                        mode_d   = mode_i;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (rd_en) begin
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    issued_d = issued_q + NW'(1);
                    grp_d    = (grp_q == k_q - NW'(1)) ? '0 : grp_q + NW'(1);
                    if (is_last_rd) state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop && flast_q[rptr_q]) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        vld_d  = (vld_q << 1) | RD_LATENCY'(rd_en);
        acc_d  = (acc_q << 1) | RD_LATENCY'(grp_q != '0);
        last_d = (last_q << 1) | RD_LATENCY'(is_last_rd);

        cred_d = cred_q + CW'(rd_en) - CW'(pop);
        fcnt_d = fcnt_q + CW'(push) - CW'(pop);
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) wptr_d = (wptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
        if (pop)  rptr_d = (rptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= '0;
            issued_q <= '0;
            num_q    <= '0;
            k_q      <= '0;
            grp_q    <= '0;
            mode_q   <= '0;
            cred_q   <= '0;
            fcnt_q   <= '0;
            vld_q    <= '0;
            acc_q    <= '0;
            last_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            fa_q     <= '{default: '0};
            fb_q     <= '{default: '0};
            facc_q   <= '0;
            flast_q  <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            addr_q   <= addr_d;
            issued_q <= issued_d;
            num_q    <= num_d;
            k_q      <= k_d;
            grp_q    <= grp_d;
            mode_q   <= mode_d;
            cred_q   <= cred_d;
            fcnt_q   <= fcnt_d;
            vld_q    <= vld_d;
            acc_q    <= acc_d;
            last_q   <= last_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            if (push) begin
                fa_q[wptr_q]    <= bus.a_rd_data;
                fb_q[wptr_q]    <= bus.b_rd_data;
                facc_q[wptr_q]  <= acc_q[RD_LATENCY-1];
                flast_q[wptr_q] <= last_q[RD_LATENCY-1];
            end
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign bus.rd_en      = rd_en;
    assign bus.rd_addr    = addr_q;
    assign bus.out_valid  = (fcnt_q != '0);
    assign bus.a_out      = fa_q[rptr_q];
    assign bus.b_out      = fb_q[rptr_q];
    assign bus.acc_en_out = facc_q[rptr_q];
    assign bus.last_out   = flast_q[rptr_q];
    assign bus.mode_out   = mode_q;
endmodule

// File: tb/tb_tile_stream_ctrl.sv
// Bench for tile_stream_ctrl: two instances (read latency 1 and 3) share stimulus; each is
// checked every cycle against a burst-level model of addresses, tiles, sideband and done.
module tb_tile_stream_ctrl;
    localparam int unsigned DW = 8;
    localparam int unsigned TS = 2;
    localparam int unsigned AW = 4;
    localparam int unsigned TW = TS * TS * DW;
    localparam int unsigned NW = AW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [NW-1:0] num = '0;
    logic [NW-1:0] klen = '0;
    logic [2:0]    mode = '0;
    logic          rdy = 1'b1;
    logic [1:0]    busy_v, done_v;

    always #5 clk = ~clk;

    tile_stream_if #(.DATA_WIDTH(DW), .TILE_SIZE(TS), .ADDR_WIDTH(AW)) bus0 ();
    tile_stream_if #(.DATA_WIDTH(DW), .TILE_SIZE(TS), .ADDR_WIDTH(AW)) bus1 ();

    tile_stream_ctrl #(.DATA_WIDTH(DW), .TILE_SIZE(TS), .ADDR_WIDTH(AW), .RD_LATENCY(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .base_addr_i(base), .num_tiles_i(num),
        .k_len_i(klen), .mode_i(mode), .busy_o(busy_v[0]), .done_o(done_v[0]), .bus(bus0)
    );
    tile_stream_ctrl #(.DATA_WIDTH(DW), .TILE_SIZE(TS), .ADDR_WIDTH(AW), .RD_LATENCY(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .base_addr_i(base), .num_tiles_i(num),
        .k_len_i(klen), .mode_i(mode), .busy_o(busy_v[1]), .done_o(done_v[1]), .bus(bus1)
    );

    // BRAM models: data for a read issued in cycle t is visible exactly in cycle t+latency.
    logic [TW-1:0] amem [16];
    logic [TW-1:0] bmem [16];
    logic [TW-1:0] apipe0, bpipe0;
    logic [TW-1:0] apipe1 [3];
    logic [TW-1:0] bpipe1 [3];
    localparam logic [TW-1:0] JUNK = 32'hdead_beef;

    always @(posedge clk) begin
        apipe0    <= bus0.rd_en ? amem[bus0.rd_addr] : JUNK;
        bpipe0    <= bus0.rd_en ? bmem[bus0.rd_addr] : ~JUNK;
        apipe1[0] <= bus1.rd_en ? amem[bus1.rd_addr] : JUNK;
        bpipe1[0] <= bus1.rd_en ? bmem[bus1.rd_addr] : ~JUNK;
        apipe1[1] <= apipe1[0];
        bpipe1[1] <= bpipe1[0];
        apipe1[2] <= apipe1[1];
        bpipe1[2] <= bpipe1[1];
    end

    assign bus0.a_rd_data = apipe0;
    assign bus0.b_rd_data = bpipe0;
    assign bus1.a_rd_data = apipe1[2];
    assign bus1.b_rd_data = bpipe1[2];
    assign bus0.out_ready = rdy;
    assign bus1.out_ready = rdy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mbusy [2];
    bit exp_done [2];
    int iss [2], pops [2], maxout [2], tot_rd [2];
    int b_base [2], b_num [2], b_k [2];
    logic [2:0] b_mode [2];
    int start_cyc [2], first_rd [2], last_rd [2], first_vld [2], last_pop [2], done_cyc [2];

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input int d, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mbusy[d] = 1'b0; exp_done[d] = 1'b0; iss[d] = 0; pops[d] = 0; maxout[d] = 0;
            b_base[d] = 0; b_num[d] = 0; b_k[d] = 0; b_mode[d] = '0;
        end
    endtask

    task automatic monitor();
        for (int d = 0; d < 2; d++) begin
            logic ve, re, ae, le, bz, dn;
            logic [AW-1:0] ra;
            logic [TW-1:0] ao, bo;
            logic [2:0] mo;
            bit accept, lastpop;
            int n, keff;
            if (d == 0) begin
                ve = bus0.out_valid; re = bus0.rd_en; ra = bus0.rd_addr; ao = bus0.a_out;
                bo = bus0.b_out; ae = bus0.acc_en_out; le = bus0.last_out; mo = bus0.mode_out;
            end else begin
                ve = bus1.out_valid; re = bus1.rd_en; ra = bus1.rd_addr; ao = bus1.a_out;
                bo = bus1.b_out; ae = bus1.acc_en_out; le = bus1.last_out; mo = bus1.mode_out;
            end
            bz = busy_v[d];
            dn = done_v[d];
            chk("busy", d, 64'(bz), 64'(mbusy[d]));
            chk("done", d, 64'(dn), 64'(exp_done[d]));
            chk("mode_out", d, 64'(mo), 64'(b_mode[d]));
            if (dn) done_cyc[d] = cyc;
            if (re) begin
                chk("rd_allowed", d, 64'(mbusy[d] && iss[d] < b_num[d]), 64'(1));
                chk("rd_addr", d, 64'(ra), 64'((b_base[d] + iss[d]) % 16));
                if (iss[d] == 0) first_rd[d] = cyc;
                last_rd[d] = cyc;
                iss[d]++;
                tot_rd[d]++;
            end
            lastpop = 1'b0;
            if (ve) begin
                n = pops[d];
                keff = (b_k[d] == 0) ? 1 : b_k[d];
                chk("valid_in_burst", d, 64'(mbusy[d] && n < b_num[d]), 64'(1));
                chk("a_out", d, 64'(ao), 64'(amem[(b_base[d] + n) % 16]));
                chk("b_out", d, 64'(bo), 64'(bmem[(b_base[d] + n) % 16]));
                chk("acc_en_out", d, 64'(ae), 64'((n % keff) != 0));
                chk("last_out", d, 64'(le), 64'(n == b_num[d] - 1));
                if (first_vld[d] < 0) first_vld[d] = cyc;
                if (rdy) begin
                    pops[d]++;
                    lastpop = (n == b_num[d] - 1);
                    last_pop[d] = cyc;
                end
            end
            if (iss[d] - pops[d] > maxout[d]) maxout[d] = iss[d] - pops[d];
            accept = start && !mbusy[d];
            exp_done[d] = lastpop || (accept && num == '0);
            if (accept) start_cyc[d] = cyc;
            if (accept && num != '0) begin
                mbusy[d] = 1'b1;
                b_base[d] = int'(base); b_num[d] = int'(num); b_k[d] = int'(klen);
                b_mode[d] = mode;
                iss[d] = 0; pops[d] = 0; maxout[d] = 0; first_rd[d] = -1; first_vld[d] = -1;
            end else if (lastpop) begin
                mbusy[d] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic burst(input int b, input int n, input int k, input int m);
        base = AW'(b); num = NW'(n); klen = NW'(k); mode = 3'(m);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input bit rnd);
        int i = 0;
        while ((mbusy[0] || mbusy[1] || exp_done[0] || exp_done[1]) && i < maxc) begin
            if (rnd) rdy = ($urandom_range(0, 3) != 0);
            step();
            i++;
        end
        rdy = 1'b1;
        chk("burst_completes", 0, 64'(mbusy[0] || mbusy[1] || exp_done[0] || exp_done[1]), 64'(0));
    endtask

    task automatic end_checks();
        for (int d = 0; d < 2; d++) begin
            chk("reads_issued", d, 64'(iss[d]), 64'(b_num[d]));
            chk("tiles_popped", d, 64'(pops[d]), 64'(b_num[d]));
            chk("outstanding_bound", d, 64'(maxout[d] <= lat(d) + 2), 64'(1));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 0, {bus0.rd_en, bus0.out_valid, bus0.acc_en_out, bus0.last_out, busy_v[0],
                     done_v[0], bus0.mode_out, bus0.rd_addr}, 64'(0));
        chk(tag, 0, {bus0.a_out, bus0.b_out}, 64'(0));
        chk(tag, 1, {bus1.rd_en, bus1.out_valid, bus1.acc_en_out, bus1.last_out, busy_v[1],
                     done_v[1], bus1.mode_out, bus1.rd_addr}, 64'(0));
        chk(tag, 1, {bus1.a_out, bus1.b_out}, 64'(0));
    endtask

    initial begin
        int s, rd_before;
        for (int i = 0; i < 16; i++) begin
            amem[i] = $urandom;
            bmem[i] = $urandom;
        end
        model_reset();
        tot_rd[0] = 0;
        tot_rd[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_zero("reset_state");
        step();

        // Basic burst with fixed cycle expectations.
        burst(2, 4, 4, 3);
        wait_idle(60, 1'b0);
        end_checks();
        s = start_cyc[0];
        chk("t1_first_rd", 0, 64'(first_rd[0] - s), 64'(1));
        chk("t1_last_rd", 0, 64'(last_rd[0] - s), 64'(4));
        chk("t1_first_valid", 0, 64'(first_vld[0] - s), 64'(3));
        chk("t1_last_pop", 0, 64'(last_pop[0] - s), 64'(6));
        chk("t1_done", 0, 64'(done_cyc[0] - s), 64'(7));
        chk("t1_first_valid", 1, 64'(first_vld[1] - start_cyc[1]), 64'(5));
        chk("t1_done", 1, 64'(done_cyc[1] - start_cyc[1]), 64'(9));
        step();

        // Accumulate grouping, including k_len=0 treated as 1.
        burst(7, 6, 2, 1);
        wait_idle(60, 1'b0);
        end_checks();
        burst(1, 3, 0, 6);
        wait_idle(60, 1'b0);
        end_checks();

        // Address wrap-around.
        burst(14, 4, 3, 2);
        wait_idle(60, 1'b0);
        end_checks();

        // Back-pressure with a start pulse while busy.
        burst(3, 8, 3, 5);
        step();
        step();
        rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                base = 4'd0; num = 5'd2; mode = 3'd1; start = 1'b1;
            end
            step();
            start = 1'b0;
        end
        rdy = 1'b1;
        wait_idle(80, 1'b0);
        end_checks();
        chk("bp_max_outstanding", 0, 64'(maxout[0]), 64'(3));
        chk("bp_max_outstanding", 1, 64'(maxout[1]), 64'(5));

        // Empty burst.
        rd_before = tot_rd[0] + tot_rd[1];
        burst(5, 0, 3, 4);
        wait_idle(10, 1'b0);
        chk("zero_done_latency", 0, 64'(done_cyc[0] - start_cyc[0]), 64'(1));
        chk("zero_no_reads", 0, 64'(tot_rd[0] + tot_rd[1]), 64'(rd_before));
        step();

        // Reset in cycle 5 of a 16-tile burst.
        burst(0, 16, 4, 7);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        repeat (4) step();
        burst(9, 5, 2, 3);
        wait_idle(60, 1'b0);
        end_checks();

        // Randomized bursts with random back-pressure.
        for (int t = 0; t < 8; t++) begin
            burst($urandom_range(0, 15), $urandom_range(1, 20), $urandom_range(0, 6),
                  $urandom_range(0, 7));
            wait_idle(400, 1'b1);
            end_checks();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tile_stream_ctrl.md
Name: tile_stream_ctrl

Overview:
- Parametrised tile feeder between two dual-port tile BRAMs (A operand, B operand) and the reconfigurable MAC array.
- Replaces the free-running address counter with a start/done-controlled burst of num_tiles reads from base_addr.
- Supports programmable BRAM read latency and per-group accumulate sequencing.
- Output is a valid/ready stream; a credit-limited output FIFO absorbs array back-pressure with no data loss.

Parameters:
- DATA_WIDTH, 16: element width.
- TILE_SIZE, 16: tile is TILE_SIZE x TILE_SIZE elements. Flat bus width TW = TILE_SIZE*TILE_SIZE*DATA_WIDTH.
- ADDR_WIDTH, 4: BRAM address width; depth is 2^ADDR_WIDTH.
- RD_LATENCY, 1: BRAM read latency in cycles. Legal range 1..4.
- FIFO_DEPTH, RD_LATENCY+2: output FIFO entries. Must be >= RD_LATENCY+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch a burst; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first tile address
- num_tiles  in  ADDR_WIDTH+1  tiles in the burst; 0 is legal
- k_len  in  ADDR_WIDTH+1  tiles per accumulate group; 0 is treated as 1
- mode_in  in  3  array mode, latched at start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at burst completion
- rd_en  out  1  BRAM port-B read enable (shared by A and B)
- rd_addr  out  ADDR_WIDTH  BRAM read address
- a_rd_data  in  TW  A BRAM read data
- b_rd_data  in  TW  B BRAM read data
- out_valid  out  1  tile available
- out_ready  in  1  array accepts tile
- a_out  out  TW  A tile
- b_out  out  TW  B tile
- acc_en_out  out  1  accumulate enable for this tile
- last_out  out  1  final tile of the burst
- mode_out  out  3  latched mode

Behaviour:
- Reset values: all outputs 0. FSM is IDLE. Counters, FIFO, credit count and latency pipe are cleared.
- Reset asserted mid-burst aborts the burst immediately. No done pulse is produced. BRAM data still in flight is discarded.
- FSM states:
  - IDLE: start=1 with num_tiles>0 latches base_addr, num_tiles, k_len and mode_in; busy goes high next cycle; go to RUN.
  - IDLE: start=1 with num_tiles=0 pulses done in the next cycle; busy stays 0; no reads are issued.
  - RUN: issue reads until num_tiles reads are issued, then go to DRAIN.
  - DRAIN: wait for the handshake on the tile with last_out=1; done pulses the cycle after that handshake; busy falls with done; return to IDLE.
- start asserted while busy=1 is ignored.
- Issue rule: rd_en=1 in a cycle iff state is RUN, reads remain, and (outstanding - pop) < FIFO_DEPTH.
  - outstanding = reads issued but not yet popped from the FIFO.
  - pop = out_valid & out_ready in the same cycle.
- rd_addr starts at base_addr and increments by 1 per issued read, modulo 2^ADDR_WIDTH (wraps 2^ADDR_WIDTH-1 -> 0).
- Sideband per tile index n (0-based): acc_en = (n mod k_len) != 0; last = (n == num_tiles-1).
- Sideband travels through an RD_LATENCY-deep shift register aligned with BRAM data.
- FIFO write: the entry (a_rd_data, b_rd_data, acc_en, last) is written at the edge ending cycle t+RD_LATENCY for a read issued in cycle t.
- FIFO is first-word-fall-through from registers. out_valid=1 whenever the FIFO is non-empty; outputs are driven from the head entry.
- Latency: start sampled in cycle 0, first rd_en in cycle 1, first out_valid in cycle RD_LATENCY+2.
- Throughput: with out_ready held high, one tile per cycle after the first.
- Simultaneous push and pop on a full FIFO is impossible by the credit rule. Simultaneous push and pop on any other FIFO state is legal and keeps the count unchanged.
- While out_valid=1 and out_ready=0, a_out, b_out, acc_en_out and last_out hold stable.
- mode_out holds the latched value until the next accepted start.
- The FIFO never overflows, and the block never drops or duplicates a tile.

Test Plan:
- RD_LATENCY=1, base_addr=2, num_tiles=4, k_len=4, out_ready=1:
  - rd_addr 2,3,4,5 in cycles 1-4.
  - out_valid in cycles 3-6 with acc_en_out 0,1,1,1 and last_out on the 4th tile.
  - done pulses in cycle 7.
- num_tiles=6, k_len=2 -> acc_en_out pattern 0,1,0,1,0,1.
- Wrap-around: ADDR_WIDTH=4, base_addr=14, num_tiles=4 -> rd_addr 14,15,0,1 and tile contents match those BRAM words.
- Back-pressure, RD_LATENCY=3:
  - out_ready low for 10 cycles mid-burst -> issued-but-unpopped reads never exceed 5.
  - Outputs hold stable while stalled.
  - All 8 tiles arrive in order.
- num_tiles=0 -> done one cycle after start, zero rd_en pulses. start asserted while busy -> ignored, no extra tiles.
- rst_n low in cycle 5 of a 16-tile burst:
  - All outputs go to 0 asynchronously and no done pulse follows.
  - A new burst after reset runs correctly from its base_addr.
